// File: rtl/moving_average_pkg.sv
// rtl/moving_average_pkg.sv - shared moving-average constants, log2 helper and sample/sum types
package moving_average_pkg;

    localparam int MA_DATA_W = 8;
    localparam int MA_DEPTH  = 4;

    // Constant-evaluable ceil(log2); callers only pass powers of two.
    function automatic int ma_log2(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int MA_SUM_W = MA_DATA_W + ma_log2(MA_DEPTH);

    typedef logic signed [MA_DATA_W-1:0] ma_sample_t;
    typedef logic signed [MA_SUM_W-1:0]  ma_sum_t;

endpackage

// File: rtl/ma_history_ring.sv
// rtl/ma_history_ring.sv - DEPTH-entry circular history with read-before-overwrite at the write pointer
module ma_history_ring
    import moving_average_pkg::*;
#(
    parameter int WIDTH = MA_SUM_W + 1,
    parameter int DEPTH = MA_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PTR_W = ma_log2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // The oldest entry lives at the write pointer, so reading there yields x[n-DEPTH].
    assign rd_data = mem[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[ptr] <= wr_data;
            if (ptr == PTR_W'(DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/moving_average_inverse.sv
// rtl/moving_average_inverse.sv - recovers samples from window sums; MA_INV_OVF_EN adds the ovf flag
module moving_average_inverse
    import moving_average_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W,
    parameter int DEPTH  = MA_DEPTH,
    parameter int SUM_W  = DATA_W + ma_log2(DEPTH)
) (
    input  logic                     system1000,
    input  logic                     system1000_rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [SUM_W-1:0]  in_sum,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
`ifdef MA_INV_OVF_EN
    output logic                     ovf,
`endif
    output logic                     primed
);

    localparam int FULL_W = SUM_W + 1;
    localparam int CNT_W  = ma_log2(DEPTH) + 1;

    logic signed [SUM_W-1:0]  s_prev;
    logic [CNT_W-1:0]         fill;
    logic [FULL_W-1:0]        hist_rd;
    logic signed [FULL_W-1:0] full;
    logic                     accept;

    assign accept = in_valid & ~clr;

    // x[n] = S[n] - S[n-1] + x[n-DEPTH], one guard bit above the sum width.
    assign full = {in_sum[SUM_W-1], in_sum} - {s_prev[SUM_W-1], s_prev} + $signed(hist_rd);

    ma_history_ring #(
        .WIDTH (FULL_W),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (system1000),
        .rst     (system1000_rst),
        .clr     (clr),
        .wr_en   (accept),
        .wr_data (full),
        .rd_data (hist_rd)
    );

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            s_prev     <= '0;
            fill       <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
            s_prev    <= '0;
            fill      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s_prev     <= in_sum;
                out_sample <= full[DATA_W-1:0];
                if (fill != CNT_W'(DEPTH)) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    assign primed = (fill == CNT_W'(DEPTH));

`ifdef MA_INV_OVF_EN
    logic in_range;

    // Representable iff every bit from the DATA_W sign bit upward matches.
    assign in_range = (&full[FULL_W-1:DATA_W-1]) | ~(|full[FULL_W-1:DATA_W-1]);

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else begin
            ovf <= in_valid & ~in_range;
        end
    end
`endif

endmodule

// File: doc/moving_average_inverse.md
MOVING_AVERAGE_INVERSE -- requirements
Module: moving_average_inverse

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the signed width of a reconstructed sample.
REQ-002 The block SHALL have parameter DEPTH, default 4, the window length; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have parameter SUM_W, default DATA_W+log2(DEPTH), the signed width of an incoming window sum.
REQ-004 Port system1000, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port system1000_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port clr, input, 1 bit: synchronous stream restart.
REQ-007 Port in_valid, input, 1 bit: qualifies in_sum for one cycle.
REQ-008 Port in_sum, input, SUM_W bits, signed: running sum of the last DEPTH samples, as produced by the team's moving-average encoder before it divides.
REQ-009 Port out_valid, output, 1 bit: qualifies out_sample.
REQ-010 Port out_sample, output, DATA_W bits, signed: reconstructed sample.
REQ-011 Port primed, output, 1 bit: at least DEPTH samples accepted since the last reset or clr.
REQ-012 Port ovf, output, 1 bit: reconstruction overflow; present only under MA_INV_OVF_EN.

Function
REQ-013 On an accepted sample (in_valid=1), the block SHALL compute x[n] = in_sum - s_prev + x[n-DEPTH] at SUM_W+1 bits. s_prev is the previously accepted sum; x[n-DEPTH] is the sample reconstructed DEPTH acceptances earlier.
REQ-014 Latency SHALL be exactly 1 cycle: out_valid and out_sample register the result on the edge that accepts in_valid.
REQ-015 out_valid SHALL be 0 in every cycle that follows a cycle with in_valid=0; out_sample SHALL hold its last value.
REQ-016 out_sample SHALL be the low DATA_W bits of the SUM_W+1 result (two's-complement wrap).
REQ-017 History SHALL be a DEPTH-entry circular buffer with a log2(DEPTH)-bit write pointer. The pointer SHALL advance only on acceptance and wrap from DEPTH-1 to 0. The entry that is read SHALL be the entry being overwritten in that cycle.
REQ-018 The stored history value SHALL be the full-width result before truncation, so that a wrapped output does not corrupt later samples.
REQ-019 A fill counter SHALL count acceptances and saturate at DEPTH. primed SHALL be 1 when the counter equals DEPTH.
REQ-020 If clr=1, the block SHALL clear the history, s_prev, pointer, fill counter, out_valid and ovf to 0 on that edge, and SHALL discard any simultaneous in_valid.
REQ-021 in_valid may be asserted on consecutive cycles; the block SHALL sustain a throughput of 1 sample per cycle with no backpressure.

Reset
REQ-022 When system1000_rst is asserted, the block SHALL immediately force to 0: out_valid, out_sample, primed, ovf, s_prev, pointer, fill counter and all history entries.
REQ-023 If reset is asserted mid-stream, the block SHALL discard any in-flight sample. After release, reconstruction SHALL restart from all-zero state, matching a freshly reset encoder.

Configuration
REQ-024 With MA_INV_OVF_EN defined: port ovf SHALL exist. ovf SHALL pulse 1 with out_valid when the full result lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1], and SHALL be 0 otherwise.
REQ-025 Without MA_INV_OVF_EN: port ovf and its logic SHALL be absent; wrap behaviour per REQ-016 SHALL be unchanged.

Structure
REQ-026 A shared package moving_average_pkg SHALL hold the default DATA_W and DEPTH constants, a function returning log2(DEPTH), and the sample and sum typedefs used by both the encoder and this block.
REQ-027 The history buffer plus its write pointer SHALL be a sub-module, ma_history_ring, parameterised by width and depth.

Verification
REQ-028 DEPTH=4: in_sum 10,30,60,100,140 on consecutive cycles -> out_sample 10,20,30,40,50, each one cycle later; primed rises with the 4th output.
REQ-029 Gapped input: same sums with in_valid low every other cycle -> identical output values; out_valid is 0 in the gap cycles.
REQ-030 Wrap: sums of 100 then 250 (x = 100, 150) -> second out_sample = -106. With the macro, ovf=1 on that cycle only. A following sum of 260 (x=10) -> out_sample 10 (history intact).
REQ-031 Reset at the 3rd sample of REQ-028: all outputs 0 immediately. Restart with sums 5,5 -> outputs 5,0; primed stays 0.
REQ-032 clr and in_valid asserted together -> that sum is ignored, fill counter is 0, and the next sum 7 -> out_sample 7.
REQ-033 Random signed samples (DEPTH=8 and DEPTH=16) through a reference encoder for 10^5 cycles -> out_sample equals the original sample at every out_valid.
